// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator.
// A prescaler turns the board clock into a step tick. Each tick advances the
// pattern register by rotate-left, rotate-right, bounce or binary count.
// Handshake: there is none. load is a single-cycle pulse that is sampled on
// every rising edge, whatever the state of en. step is a one-cycle strobe
// that rises together with the led value changed by the tick.
module led_sequencer #(
    parameter int           N             = 8,
    parameter int           BASE_SHIFT    = 22,
    parameter logic [N-1:0] RESET_PATTERN = {{(N-1){1'b0}}, 1'b1},
    parameter bit           ACTIVE_LOW    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic [2:0]   speed,
    input  logic         load,
    input  logic [N-1:0] load_pattern,
    output logic [N-1:0] led,
    output logic         step
);

    localparam int CNT_W = BASE_SHIFT + 8;

    logic [CNT_W-1:0] prescaler;
    logic [CNT_W-1:0] term;
    logic [N-1:0]     pattern;
    logic [N-1:0]     pat_next;
    logic             dir;       // bounce direction: 0 = left, 1 = right
    logic             dir_next;
    logic             tick;

    // Terminal count for the selected speed. The largest shift is
    // BASE_SHIFT+7, so the result always fits in CNT_W bits.
    assign term = (CNT_W'(1) << (BASE_SHIFT + int'(speed))) - CNT_W'(1);

    // The >= compare lets a speed decrease fire on the next enabled cycle
    // instead of wrapping all the way around the counter.
    assign tick = en && (prescaler >= term);

    // Compute the next pattern and bounce direction for the current mode.
    always_comb begin
        pat_next = pattern;
        dir_next = dir;
        case (mode)
            2'd0: pat_next = {pattern[N-2:0], pattern[N-1]};
            2'd1: pat_next = {pattern[0], pattern[N-1:1]};
            2'd2: begin
                if (!dir) begin
                    if (pattern[N-1]) begin
                        dir_next = 1'b1;
                        pat_next = pattern >> 1;
                    end else begin
                        pat_next = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        dir_next = 1'b0;
                        pat_next = pattern << 1;
                    end else begin
                        pat_next = pattern >> 1;
                    end
                end
            end
            default: pat_next = pattern + {{(N-1){1'b0}}, 1'b1};
        endcase
    end

    // Prescaler, pattern, direction and step strobe. Load wins over a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            pattern   <= RESET_PATTERN;
            dir       <= 1'b0;
            step      <= 1'b0;
        end else if (load) begin
            prescaler <= '0;
            pattern   <= load_pattern;
            dir       <= 1'b0;
            step      <= 1'b0;
        end else if (tick) begin
            prescaler <= '0;
            pattern   <= pat_next;
            dir       <= dir_next;
            step      <= 1'b1;
        end else if (en) begin
            prescaler <= prescaler + CNT_W'(1);
            step      <= 1'b0;
        end else begin
            step      <= 1'b0;
        end
    end

    // The LED bank follows the pattern directly, optionally inverted.
    assign led = pattern ^ {N{ACTIVE_LOW}};

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer. Two instances share all inputs: dut_al is
// active-low (led = ~pattern), dut_ah is active-high (led = pattern).
// Expected patterns are queued when stimulus is driven and popped at each step.
module tb_led_sequencer;

    localparam int N  = 8;
    localparam int BS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [2:0]   speed;
    logic         load;
    logic [N-1:0] load_pattern;
    logic [N-1:0] led_al;
    logic [N-1:0] led_ah;
    logic         step_al;
    logic         step_ah;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [N-1:0] exp_q[$];

    led_sequencer #(.N(N), .BASE_SHIFT(BS), .RESET_PATTERN(8'h01), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .load(load),
        .load_pattern(load_pattern), .led(led_al), .step(step_al)
    );

    led_sequencer #(.N(N), .BASE_SHIFT(BS), .RESET_PATTERN(8'h01), .ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .load(load),
        .load_pattern(load_pattern), .led(led_ah), .step(step_ah)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count edges until the next step strobe, bounded.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step_al && n < 100);
        if (!step_al) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step_timeout: no step in %0d cycles, required a step", n);
        end
    endtask

    task automatic do_load(input logic [N-1:0] p, input logic [1:0] m, input logic [2:0] s);
        mode         = m;
        speed        = s;
        load_pattern = p;
        load         = 1'b1;
        cyc();
        load         = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 2'd0; speed = 3'd0; load = 1'b0; load_pattern = '0;
        cyc();
        cyc();
        n_cmp++;
        if (led_al !== 8'hFE || led_ah !== 8'h01 || step_al !== 1'b0 || step_ah !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: led_al=%h led_ah=%h step=%b%b, required fe 01 00",
                     led_al, led_ah, step_al, step_ah);
        end
    endtask

    task automatic test_rotate_left();
        int n;
        logic [N-1:0] e;
        en = 1'b1; mode = 2'd0; speed = 3'd0;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(1 << i));
        while (exp_q.size() > 0) begin
            wait_step(n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n != 4 || led_ah !== e || led_al !== ~e || step_ah !== 1'b1) begin
                n_bad++;
                $display("FAIL rotate_left: cycles=%0d led_al=%h led_ah=%h, required 4 %h %h",
                         n, led_al, led_ah, ~e, e);
            end
        end
    endtask

    task automatic test_rotate_right();
        int n;
        logic [N-1:0] e;
        do_load(8'h01, 2'd1, 3'd0);
        n_cmp++;
        if (step_al !== 1'b0 || led_ah !== 8'h01 || led_al !== 8'hFE) begin
            n_bad++;
            $display("FAIL rr_load: step=%b led_al=%h led_ah=%h, required 0 fe 01", step_al, led_al, led_ah);
        end
        for (int i = 7; i >= 0; i--) exp_q.push_back(8'(1 << i));
        exp_q.push_back(8'h80);
        while (exp_q.size() > 0) begin
            wait_step(n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n != 4 || led_ah !== e || led_al !== ~e) begin
                n_bad++;
                $display("FAIL rotate_right: cycles=%0d led_ah=%h led_al=%h, required 4 %h %h",
                         n, led_ah, led_al, e, ~e);
            end
        end
    endtask

    task automatic test_bounce();
        int n;
        logic [N-1:0] e;
        do_load(8'h01, 2'd2, 3'd0);
        for (int i = 1; i <= 7; i++) exp_q.push_back(8'(1 << i));
        for (int i = 6; i >= 0; i--) exp_q.push_back(8'(1 << i));
        exp_q.push_back(8'h02);
        while (exp_q.size() > 0) begin
            wait_step(n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n != 4 || led_ah !== e || led_al !== ~e) begin
                n_bad++;
                $display("FAIL bounce: cycles=%0d led_ah=%h, required 4 %h", n, led_ah, e);
            end
        end
    endtask

    task automatic test_count();
        int n;
        logic [N-1:0] e;
        do_load(8'hFE, 2'd3, 3'd0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        while (exp_q.size() > 0) begin
            wait_step(n);
            e = exp_q.pop_front();
            n_cmp++;
            if (n != 4 || led_ah !== e || led_al !== ~e) begin
                n_bad++;
                $display("FAIL count: cycles=%0d led_ah=%h, required 4 %h", n, led_ah, e);
            end
        end
    endtask

    task automatic test_speed();
        int n;
        logic [N-1:0] e;
        logic bad;
        do_load(8'h00, 2'd3, 3'd2);
        exp_q.push_back(8'h01);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 16 || led_ah !== e) begin
            n_bad++;
            $display("FAIL speed2_period: cycles=%0d led_ah=%h, required 16 %h", n, led_ah, e);
        end
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (step_al !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL speed2_quiet: step seen before count 9, required none");
        end
        speed = 3'd0;
        exp_q.push_back(8'h02);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 1 || led_ah !== e) begin
            n_bad++;
            $display("FAIL speed_drop: cycles=%0d led_ah=%h, required 1 %h", n, led_ah, e);
        end
        exp_q.push_back(8'h03);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 4 || led_ah !== e) begin
            n_bad++;
            $display("FAIL speed0_period: cycles=%0d led_ah=%h, required 4 %h", n, led_ah, e);
        end
    endtask

    task automatic test_enable();
        int n;
        logic [N-1:0] e;
        logic bad;
        do_load(8'h01, 2'd0, 3'd0);
        cyc();
        cyc();
        en = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (step_al !== 1'b0 || led_ah !== 8'h01) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL en_hold: led_ah=%h step=%b during en=0, required 01 0", led_ah, step_al);
        end
        en = 1'b1;
        exp_q.push_back(8'h02);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 2 || led_ah !== e) begin
            n_bad++;
            $display("FAIL en_resume: cycles=%0d led_ah=%h, required 2 %h", n, led_ah, e);
        end
    endtask

    task automatic test_load_in_tick();
        int n;
        logic [N-1:0] e;
        exp_q.push_back(8'h04);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 4 || led_ah !== e) begin
            n_bad++;
            $display("FAIL pre_load_step: cycles=%0d led_ah=%h, required 4 %h", n, led_ah, e);
        end
        cyc();
        cyc();
        cyc();
        do_load(8'hA5, 2'd0, 3'd0);
        n_cmp++;
        if (step_al !== 1'b0 || led_ah !== 8'hA5 || led_al !== 8'h5A) begin
            n_bad++;
            $display("FAIL load_in_tick: step=%b led_ah=%h led_al=%h, required 0 a5 5a",
                     step_al, led_ah, led_al);
        end
        exp_q.push_back(8'h4B);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 4 || led_ah !== e) begin
            n_bad++;
            $display("FAIL after_load: cycles=%0d led_ah=%h, required 4 %h", n, led_ah, e);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [N-1:0] e;
        wait_step(n);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (step_al !== 1'b0 || step_ah !== 1'b0 || led_al !== 8'hFE || led_ah !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_mid: step=%b led_al=%h led_ah=%h, required 0 fe 01",
                     step_al, led_al, led_ah);
        end
        cyc();
        rst = 1'b0;
        exp_q.push_back(8'h02);
        wait_step(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n != 4 || led_ah !== e || led_al !== ~e) begin
            n_bad++;
            $display("FAIL reset_restart: cycles=%0d led_ah=%h, required 4 %h", n, led_ah, e);
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_bounce();
        test_count();
        test_speed();
        test_enable();
        test_load_in_tick();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for board bring-up and status display. A programmable prescaler divides the board clock into a step tick, and each tick advances an N-bit pattern register by one of four modes: rotate left, rotate right, bounce, or binary count. Runtime controls cover enable, speed and pattern load. The block drives the board LED bank directly and offers a step strobe for GPIO or debug.

## Interface
- N, default 8: pattern/LED width; N >= 2
- BASE_SHIFT, default 22: log2 of the tick period at speed = 0; benches use 2
- RESET_PATTERN, default 1 (N bits): pattern register value at reset
- ACTIVE_LOW, default 1: when 1, led = ~pattern; when 0, led = pattern

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run when 1; when 0, prescaler and pattern hold and step = 0
- mode  in  2  0 rotate left, 1 rotate right, 2 bounce, 3 binary count
- speed  in  3  tick period = 2^(BASE_SHIFT+speed) clk cycles
- load  in  1  one-cycle pulse; loads load_pattern
- load_pattern  in  N  value captured when load = 1
- led  out  N  pattern, inverted when ACTIVE_LOW = 1
- step  out  1  one-cycle pulse, high in the cycle a tick-driven pattern change becomes visible

## Operation
- Prescaler: CNT_W = BASE_SHIFT+8 bits. Terminal T = 2^(BASE_SHIFT+speed) - 1. When en = 1 and prescaler >= T, tick = 1 and prescaler <= 0. Otherwise, when en = 1, prescaler <= prescaler + 1.
- The >= compare is mandatory. If speed drops mid-period below the current count, the tick fires on the next enabled cycle. There is no long wrap.
- Direction register dir: 0 = left, 1 = right. It is used only in mode 2.
- On tick, per mode:
  - mode 0: pattern <= {pattern[N-2:0], pattern[N-1]}
  - mode 1: pattern <= {pattern[0], pattern[N-1:1]}
  - mode 2, dir = 0: if pattern[N-1], dir <= 1 and pattern <= pattern >> 1; otherwise pattern <= pattern << 1. Zero fill.
  - mode 2, dir = 1: if pattern[0], dir <= 0 and pattern <= pattern << 1; otherwise pattern <= pattern >> 1. Zero fill.
  - mode 2 with all-zero pattern: pattern stays 0 and dir keeps toggling rules as above; no special case.
  - mode 3: pattern <= pattern + 1, modulo 2^N. All-ones wraps to 0.
- Load has priority over tick in the same cycle. It sets pattern <= load_pattern, dir <= 0 and prescaler <= 0. It asserts no step.
- Load is honoured even when en = 0.
- A mode change takes effect on the next tick. dir is not cleared by a mode change.
- led is a combinational function of pattern only; it is not registered separately.

## Timing
- Reset values (async, immediate): pattern = RESET_PATTERN, dir = 0, prescaler = 0, step = 0, led = RESET_PATTERN ^ {N{ACTIVE_LOW}}. With defaults, led = 8'hFE.
- With en = 1 after rst falls, the first tick occurs at rising edge number 2^(BASE_SHIFT+speed). The pattern and step update on that edge.
- step is high for exactly one cycle per tick, aligned with the new led value.
- Steady-state tick period is exactly 2^(BASE_SHIFT+speed) cycles while speed is constant.
- Dropping en freezes the prescaler count; raising en resumes from the held count, not from 0.
- rst asserted mid-period clears everything in the same instant. There is no partial update.

## Test plan
- Reset, N=8, BASE_SHIFT=2, ACTIVE_LOW=1, RESET_PATTERN=1, mode 0, speed 0, en=1 -> led = FE; led = FD at edge 4, FB at edge 8; step high only at edges 4, 8, ...
- ACTIVE_LOW=0, mode 1, load 0x01 -> led sequence 80, 40, 20, ..., 01, 80, with 4 cycles per step.
- Mode 2, load 0x01 -> 02, 04, ..., 80, 40, ..., 01, 02. dir flips exactly at 80 and 01; there are no repeated values at the ends.
- Mode 3, load 0xFE -> FF, then 00, then 01.
- speed 2 -> 16-cycle period. Switch speed to 0 when the count is 9 -> tick on the next edge, then a 4-cycle period.
- en=0 for 10 cycles mid-period -> no step and led held; the period completes with the remaining count. load asserted in a tick cycle -> pattern = load_pattern, no step, next tick 4 cycles later. rst pulse mid-run -> led = FE immediately.
